ifetch_dispatch: RTL and testbench

IFETCH_DISPATCH -- requirements
Module: ifetch_dispatch

---
 rtl/ifetch_dispatch.sv | 108 ++++++++++
 tb/tb_ifetch_dispatch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_dispatch.sv
// rtl/ifetch_dispatch.sv - instruction fetch/dispatch: pops FIFO ops, performs reads, presents results
// READ ops go to memory, NOP is dropped, anything else returns an error result.
module ifetch_dispatch (
  input  logic        clk,
  input  logic        reset,
  input  logic        ififo_empty,
  input  logic [23:0] ififo_do,
  output logic        ififo_unshift,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        result_valid,
  output logic [4:0]  result_op,
  output logic [2:0]  result_tag,
  output logic [15:0] result_data,
  output logic        result_err,
  input  logic        result_accept
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_READ = 5'h02;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  op_q;
  logic [2:0]  tag_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        err_q;
  logic        flush_seen;

  logic [4:0]  head_op;
  logic        pop;
  logic        drop;

  assign head_op = ififo_do[23:19];
  // Reset counts as an empty FIFO so nothing is popped while it is held.
  assign pop     = (state == IDLE) && !ififo_empty && !flush && !reset;
  assign drop    = flush || flush_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pop) begin
          if (head_op == OP_READ)     state_next = REQ;
          else if (head_op != OP_NOP) state_next = RESP;
        end
      end
      REQ: begin
        // The bus cycle always completes; a flush only decides whether the data is kept.
        if (mem_ack) state_next = drop ? IDLE : RESP;
      end
      RESP: begin
        if (flush || result_accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ififo_unshift = pop;
    mem_req       = (state == REQ);
    mem_addr      = addr_q;
    result_valid  = (state == RESP);
    result_op     = op_q;
    result_tag    = tag_q;
    result_data   = data_q;
    result_err    = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= 5'h00;
      tag_q      <= 3'h0;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      err_q      <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      if (pop) begin
        op_q   <= head_op;
        tag_q  <= ififo_do[18:16];
        addr_q <= ififo_do[15:0];
        data_q <= 16'h0000;
        err_q  <= (head_op != OP_READ) && (head_op != OP_NOP);
      end
      if (state == REQ) begin
        if (mem_ack) begin
          if (!drop) data_q <= mem_data;
          flush_seen <= 1'b0;
        end else if (flush) begin
          flush_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_dispatch.sv
// tb/tb_ifetch_dispatch.sv - randomized check of ifetch_dispatch against a transaction-phase model
module tb_ifetch_dispatch;

  logic        clk;
  logic        reset;
  logic        ififo_empty;
  logic [23:0] ififo_do;
  logic        ififo_unshift;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        result_valid;
  logic [4:0]  result_op;
  logic [2:0]  result_tag;
  logic [15:0] result_data;
  logic        result_err;
  logic        result_accept;

  ifetch_dispatch dut (
    .clk           (clk),
    .reset         (reset),
    .ififo_empty   (ififo_empty),
    .ififo_do      (ififo_do),
    .ififo_unshift (ififo_unshift),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .result_valid  (result_valid),
    .result_op     (result_op),
    .result_tag    (result_tag),
    .result_data   (result_data),
    .result_err    (result_err),
    .result_accept (result_accept)
  );

  always #5 clk = ~clk;

  localparam int PH_IDLE   = 0;
  localparam int PH_MEM    = 1;
  localparam int PH_RESULT = 2;

  int          vectors;
  int          errors;
  int          n_resets;
  int          m_phase;
  logic        m_flushed;
  logic [4:0]  m_op;
  logic [2:0]  m_tag;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  logic        m_err;
  logic        e_unshift;
  logic [23:0] fifo_q[$];
  logic [23:0] head;

  function automatic logic [23:0] gen_entry();
    int r;
    logic [4:0] op;
    r = $urandom_range(0, 9);
    if (r < 2)      op = 5'h00;
    else if (r < 7) op = 5'h02;
    else            op = 5'($urandom);
    return {op, 3'($urandom), 16'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 0; reset = 1; flush = 0; mem_ack = 0; mem_data = 16'h0;
    result_accept = 0; vectors = 0; errors = 0; n_resets = 0;
    m_phase = PH_IDLE; m_flushed = 0;
    m_op = 0; m_tag = 0; m_addr = 0; m_data = 0; m_err = 0;
    fifo_q.push_back({5'h02, 3'h7, 16'h8000});
    ififo_empty = 0;
    ififo_do = fifo_q[0];

    // Reset held with a non-empty FIFO: everything quiet and zero.
    #3;
    check("reset_unshift", ififo_unshift, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_valid", result_valid, 0);
    check("reset_op", result_op, 0);
    check("reset_tag", result_tag, 0);
    check("reset_data", result_data, 0);
    check("reset_err", result_err, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("reset_hold_unshift", ififo_unshift, 0);
    check("reset_hold_state", mem_req | result_valid, 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      reset = 0;
      while (fifo_q.size() < 4) fifo_q.push_back(gen_entry());
      flush         = ($urandom_range(0, 11) == 0);
      ififo_empty   = ($urandom_range(0, 5) == 0);
      ififo_do      = fifo_q[0];
      mem_ack       = ($urandom_range(0, 2) == 0);
      mem_data      = 16'($urandom);
      result_accept = 1'($urandom_range(0, 1));
      #2;

      e_unshift = (m_phase == PH_IDLE) && !ififo_empty && !flush;
      check("unshift", ififo_unshift, e_unshift);
      check("mem_req", mem_req, m_phase == PH_MEM);
      check("result_valid", result_valid, m_phase == PH_RESULT);
      if (m_phase == PH_MEM) check("mem_addr", mem_addr, m_addr);
      if (m_phase == PH_RESULT) begin
        check("result_op", result_op, m_op);
        check("result_tag", result_tag, m_tag);
        check("result_data", result_data, m_data);
        check("result_err", result_err, m_err);
      end

      if (m_phase != PH_IDLE && n_resets < 6 && $urandom_range(0, 39) == 0) begin
        // Asynchronous reset in the middle of an operation: abandoned at once.
        reset = 1;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_unshift", ififo_unshift, 0);
        check("midrst_data", result_data, 0);
        check("midrst_addr", mem_addr, 0);
        m_phase = PH_IDLE; m_flushed = 0;
        m_op = 0; m_tag = 0; m_addr = 0; m_data = 0; m_err = 0;
        n_resets++;
      end else begin
        case (m_phase)
          PH_IDLE: begin
            if (e_unshift) begin
              head = fifo_q.pop_front();
              m_op = head[23:19]; m_tag = head[18:16]; m_addr = head[15:0];
              m_data = 16'h0000;
              if (m_op == 5'h02) begin
                m_err = 0; m_phase = PH_MEM;
              end else if (m_op != 5'h00) begin
                m_err = 1; m_phase = PH_RESULT;
              end else begin
                m_err = 0;
              end
            end
          end
          PH_MEM: begin
            if (mem_ack) begin
              if (m_flushed || flush) m_phase = PH_IDLE;
              else begin
                m_data = mem_data; m_phase = PH_RESULT;
              end
              m_flushed = 0;
            end else if (flush) begin
              m_flushed = 1;
            end
          end
          default: begin
            if (flush || result_accept) m_phase = PH_IDLE;
          end
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
